lmac_stats_regs: RTL and testbench
==================================

# lmac_stats_regs

Per-channel MAC statistics collector and register-read port for multi-channel LMAC designs. It sits beside one or more LMAC instances, consumes per-frame TX/RX statistics strobes, and maintains saturating frame, byte and error counters for each channel. Software reads the counters through the existing `host_addr_reg` / `reg_rd_start` / `reg_rd_done_out` / `FMAC_REGDOUT` handshake. This block generalises the single-MAC read port to NCH channels, wide counters, snapshot reads and optional clear-on-read.

## Interface
- NCH, 4: number of MAC channels (1..16).
- CNT_W, 48: counter width (33..64). Values are read as lo and hi 32-bit words.
- LEN_W, 16: width of the per-frame byte-length field.
- CLEAR_ON_READ, 0: when set to 1, a lo-word read clears the counter being read.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- tx_stat_valid  in  NCH  one-cycle strobe per completed TX frame, one bit per channel.
- tx_stat_err  in  NCH  TX frame errored; qualified by tx_stat_valid.
- tx_stat_len  in  NCH*LEN_W  TX frame byte count; channel c occupies bits [c*LEN_W +: LEN_W].
- rx_stat_valid, rx_stat_err, rx_stat_len  in  NCH, NCH, NCH*LEN_W  RX equivalents of the TX inputs.
- stats_clr  in  1  global clear of all counters.
- host_addr_reg  in  16  read address.
- reg_rd_start  in  1  one-cycle read request.
- reg_rd_done_out  out  1  one-cycle read completion strobe.
- FMAC_REGDOUT  out  32  read data.

## Operation
- Counters, per channel: index 0 tx_frames, 1 tx_bytes, 2 tx_errors, 3 rx_frames, 4 rx_bytes, 5 rx_errors.
- Update rule for a valid strobe:
  - err=0: frames is incremented by 1 and bytes by len.
  - err=1: only errors is incremented by 1. Frames and bytes are unchanged.
- Counters saturate at 2^CNT_W−1 and never wrap. Byte additions clamp to the maximum value.
- Address decode:
  - addr[0] selects the word: 0 = lo (bits 31:0), 1 = hi (bits CNT_W−1:32, zero-extended).
  - addr[3:1] is the counter index.
  - addr[15:4] is the channel.
  - An index of 6 or 7, or a channel ≥ NCH, reads 0. Such a read has no side effects but still completes.
- Snapshot behaviour:
  - A lo-word read captures the full counter.
  - The hi word of the captured value goes into a single hi_shadow register.
  - A hi-word read returns hi_shadow regardless of its own address. Reading lo then hi therefore gives a coherent 64-bit value.
- CLEAR_ON_READ=1:
  - A lo read resets the addressed counter in the same edge as the capture.
  - An increment arriving in that same cycle is not lost: the counter becomes that increment's value.
- stats_clr clears every counter and hi_shadow. An increment in the same cycle is discarded, because the clear wins.
- A reg_rd_start arriving while a read is in flight is ignored. Only one read is outstanding at a time.

## Timing
- Reset: all counters, hi_shadow and FMAC_REGDOUT are 0, reg_rd_done_out is 0, and the read pipeline is idle.
- An increment whose strobe is valid in cycle T is visible in the counter from cycle T+1.
- Read with reg_rd_start high in cycle T:
  - host_addr_reg is sampled in cycle T.
  - The selected counter value is the register contents during T, i.e. it includes strobes up to T−1.
  - The capture and any clear-on-read happen at the end of T.
  - reg_rd_done_out is high for exactly cycle T+2, with FMAC_REGDOUT valid.
  - FMAC_REGDOUT holds its value until the next completion.
- Read latency is fixed at 2. A new start is accepted from cycle T+2 onward; a start in T+1 is ignored.
- If rst is asserted mid-read, the in-flight read is dropped and no done strobe is issued.

## Structure
- Package lmac_stats_pkg holds:
  - the counter index constants (CTR_TX_FRAMES..CTR_RX_ERRORS);
  - NUM_CTR=6;
  - the address field positions (word bit, index field, channel field).
- Sub-module lmac_stat_ctr implements one saturating counter with add value, add enable, read-clear and global clear. It is instantiated NUM_CTR*NCH times. The top level holds the address decode/mux, the two-stage read pipeline and hi_shadow.

## Test plan
- Saturating bytes: NCH=4, CNT_W=48. Three TX strobes on channel 2 with len 64, 1518 and 9000, then read addr 0x0022 (ch2, tx_bytes, lo). Required: done in T+2, data 10582.
- Error-only increment: RX strobe on channel 1 with err=1. Required: rx_errors=1, and rx_frames and rx_bytes stay 0.
- Saturation and coherent hi read: preload tx_bytes ch0 to 2^48−100 with strobes, add len 500. Required: lo read gives 0xFFFFFFFF; then a hi read of any address gives 0x0000FFFF.
- Clear-on-read race: CLEAR_ON_READ=1, and a read of ch3 tx_frames (value 5) coincides with a new TX strobe on ch3. Required: the read returns 5 and the counter becomes 1.
- Busy and out-of-range reads: a start at T+1 is ignored (exactly one done). A read of channel 7 with NCH=4 returns 0 with done. stats_clr during a strobe leaves all counters at 0.
- Reset mid-read: rst in cycle T+1 produces no done, and all outputs are 0 afterwards.

Source files
------------

// File: rtl/lmac_stats_pkg.sv
// Shared constants for the LMAC statistics block: counter indices and the
// register address layout {channel[15:4], index[3:1], word[0]}.
package lmac_stats_pkg;

    localparam int NUM_CTR       = 6;
    localparam int CTR_TX_FRAMES = 0;
    localparam int CTR_TX_BYTES  = 1;
    localparam int CTR_TX_ERRORS = 2;
    localparam int CTR_RX_FRAMES = 3;
    localparam int CTR_RX_BYTES  = 4;
    localparam int CTR_RX_ERRORS = 5;

    localparam int ADDR_W        = 16;
    localparam int ADDR_WORD_BIT = 0;
    localparam int ADDR_IDX_LSB  = 1;
    localparam int ADDR_IDX_W    = 3;
    localparam int ADDR_CH_LSB   = 4;
    localparam int ADDR_CH_W     = 12;

    function automatic int ctr_slot(input int ch, input int idx);
        return ch * NUM_CTR + idx;
    endfunction

endpackage

// File: rtl/lmac_stats_regs_if.sv
// Host register-read handshake: one-cycle start with address in, one-cycle
// done strobe with 32-bit data out.
interface lmac_stats_regs_if;
    import lmac_stats_pkg::*;

    logic [ADDR_W-1:0] host_addr_reg;
    logic              reg_rd_start;
    logic              reg_rd_done_out;
    logic [31:0]       FMAC_REGDOUT;

    modport master (output host_addr_reg, output reg_rd_start,
                    input  reg_rd_done_out, input FMAC_REGDOUT);
    modport slave  (input  host_addr_reg, input reg_rd_start,
                    output reg_rd_done_out, output FMAC_REGDOUT);
endinterface

// File: rtl/lmac_stat_ctr.sv
// One saturating statistics counter with add, read-clear and global clear.
// Latency: update visible the cycle after add_en; no backpressure.
module lmac_stat_ctr #(
    parameter int CNT_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             rd_clr,
    input  logic             add_en,
    input  logic [CNT_W-1:0] add_val,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] base;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] nxt;

    // A read-clear in the same cycle as an add restarts the count from the add.
    always_comb begin
        base = rd_clr ? '0 : cnt;
        sum  = {1'b0, base} + {1'b0, add_val};
        nxt  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (add_en) begin
            cnt <= nxt;
        end else if (rd_clr) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/lmac_stats_regs.sv
// Per-channel saturating TX/RX frame/byte/error counters with a snapshot read port.
// Latency: done two cycles after an accepted start; starts while busy are dropped.
module lmac_stats_regs
    import lmac_stats_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int CNT_W         = 48,
    parameter int LEN_W         = 16,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       tx_stat_valid,
    input  logic [NCH-1:0]       tx_stat_err,
    input  logic [NCH*LEN_W-1:0] tx_stat_len,
    input  logic [NCH-1:0]       rx_stat_valid,
    input  logic [NCH-1:0]       rx_stat_err,
    input  logic [NCH*LEN_W-1:0] rx_stat_len,
    input  logic                 stats_clr,
    lmac_stats_regs_if.slave     host
);

    localparam int NSLOT = NCH * NUM_CTR;

    logic [CNT_W-1:0] cnt_q [NSLOT];
    logic [NSLOT-1:0] rd_clr;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        for (genvar k = 0; k < NUM_CTR; k++) begin : g_ctr
            localparam bit IS_RX    = (k >= CTR_RX_FRAMES);
            localparam bit IS_BYTES = (k == CTR_TX_BYTES) || (k == CTR_RX_BYTES);
            localparam bit IS_ERR   = (k == CTR_TX_ERRORS) || (k == CTR_RX_ERRORS);

            logic             vld;
            logic             err;
            logic [LEN_W-1:0] len;
            logic             add_en;
            logic [CNT_W-1:0] add_val;

            assign vld     = IS_RX ? rx_stat_valid[c] : tx_stat_valid[c];
            assign err     = IS_RX ? rx_stat_err[c]   : tx_stat_err[c];
            assign len     = IS_RX ? rx_stat_len[c*LEN_W +: LEN_W]
                                   : tx_stat_len[c*LEN_W +: LEN_W];
            assign add_en  = vld && (IS_ERR ? err : !err);
            assign add_val = IS_BYTES ? CNT_W'(len) : CNT_W'(1);

            lmac_stat_ctr #(.CNT_W(CNT_W)) u_ctr (
                .clk     (clk),
                .rst     (rst),
                .clr     (stats_clr),
                .rd_clr  (rd_clr[ctr_slot(c, k)]),
                .add_en  (add_en),
                .add_val (add_val),
                .cnt     (cnt_q[ctr_slot(c, k)])
            );
        end
    end

    logic                  s1_vld;
    logic [31:0]           s1_dat;
    logic [31:0]           hi_shadow;
    logic [ADDR_CH_W-1:0]  rd_ch;
    logic [ADDR_IDX_W-1:0] rd_idx;
    logic                  rd_hi;
    logic                  rd_acc;
    logic                  in_range;
    logic [CNT_W-1:0]      sel;
    logic [63:0]           sel64;

    assign rd_ch    = host.host_addr_reg[ADDR_CH_LSB +: ADDR_CH_W];
    assign rd_idx   = host.host_addr_reg[ADDR_IDX_LSB +: ADDR_IDX_W];
    assign rd_hi    = host.host_addr_reg[ADDR_WORD_BIT];
    assign rd_acc   = host.reg_rd_start && !s1_vld;
    assign in_range = (int'(rd_idx) < NUM_CTR) && (int'(rd_ch) < NCH);
    assign sel64    = 64'(sel);

    always_comb begin
        sel    = '0;
        rd_clr = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (in_range && i == ctr_slot(int'(rd_ch), int'(rd_idx))) begin
                sel       = cnt_q[i];
                rd_clr[i] = (CLEAR_ON_READ != 0) && rd_acc && !rd_hi;
            end
        end
    end

    // Stage 1 captures the snapshot at the start edge; stage 2 presents it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld               <= 1'b0;
            s1_dat               <= '0;
            hi_shadow            <= '0;
            host.reg_rd_done_out <= 1'b0;
            host.FMAC_REGDOUT    <= '0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_dat <= rd_hi ? hi_shadow : sel64[31:0];
            end
            if (stats_clr) begin
                hi_shadow <= '0;
            end else if (rd_acc && !rd_hi && in_range) begin
                hi_shadow <= sel64[63:32];
            end
            host.reg_rd_done_out <= s1_vld;
            if (s1_vld) begin
                host.FMAC_REGDOUT <= s1_dat;
            end
        end
    end

endmodule

// File: tb/tb_lmac_stats_regs.sv
// Directed bench: two instances (plain and clear-on-read) share stat inputs.
module tb_lmac_stats_regs;

    localparam int NCH   = 4;
    localparam int CNT_W = 48;
    localparam int LEN_W = 48;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NCH-1:0]       tx_v = '0, tx_e = '0, rx_v = '0, rx_e = '0;
    logic [NCH*LEN_W-1:0] tx_l = '0, rx_l = '0;
    logic                 clr = 1'b0;
    int                   n_chk = 0;
    int                   n_err = 0;

    lmac_stats_regs_if bus0 ();
    lmac_stats_regs_if bus1 ();

    always #5 clk = ~clk;

    lmac_stats_regs #(.NCH(NCH), .CNT_W(CNT_W), .LEN_W(LEN_W), .CLEAR_ON_READ(0)) u_dut (
        .clk(clk), .rst(rst),
        .tx_stat_valid(tx_v), .tx_stat_err(tx_e), .tx_stat_len(tx_l),
        .rx_stat_valid(rx_v), .rx_stat_err(rx_e), .rx_stat_len(rx_l),
        .stats_clr(clr), .host(bus0)
    );

    lmac_stats_regs #(.NCH(NCH), .CNT_W(CNT_W), .LEN_W(LEN_W), .CLEAR_ON_READ(1)) u_dut_cor (
        .clk(clk), .rst(rst),
        .tx_stat_valid(tx_v), .tx_stat_err(tx_e), .tx_stat_len(tx_l),
        .rx_stat_valid(rx_v), .rx_stat_err(rx_e), .rx_stat_len(rx_l),
        .stats_clr(clr), .host(bus1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_strobe(input bit rx, input int ch, input bit err, input logic [LEN_W-1:0] len);
        if (rx) begin
            rx_v[ch] = 1'b1; rx_e[ch] = err; rx_l[ch*LEN_W +: LEN_W] = len;
        end else begin
            tx_v[ch] = 1'b1; tx_e[ch] = err; tx_l[ch*LEN_W +: LEN_W] = len;
        end
    endtask

    task automatic clr_strobe();
        tx_v = '0; tx_e = '0; rx_v = '0; rx_e = '0; clr = 1'b0;
    endtask

    task automatic strobe(input bit rx, input int ch, input bit err, input logic [LEN_W-1:0] len);
        set_strobe(rx, ch, err, len);
        tick();
        clr_strobe();
    endtask

    task automatic start_rd(input int d, input logic [15:0] addr);
        if (d == 0) begin
            bus0.host_addr_reg = addr; bus0.reg_rd_start = 1'b1;
        end else begin
            bus1.host_addr_reg = addr; bus1.reg_rd_start = 1'b1;
        end
    endtask

    task automatic stop_rd();
        bus0.reg_rd_start = 1'b0;
        bus1.reg_rd_start = 1'b0;
    endtask

    function automatic logic done_of(input int d);
        return (d == 0) ? bus0.reg_rd_done_out : bus1.reg_rd_done_out;
    endfunction

    function automatic logic [31:0] data_of(input int d);
        return (d == 0) ? bus0.FMAC_REGDOUT : bus1.FMAC_REGDOUT;
    endfunction

    task automatic rd(input int d, input logic [15:0] addr, input logic [31:0] exp, input string tag);
        start_rd(d, addr);
        tick();
        stop_rd();
        chk({tag, " done@T+1"}, 64'(done_of(d)), 64'd0);
        tick();
        chk({tag, " done@T+2"}, 64'(done_of(d)), 64'd1);
        chk({tag, " data"}, 64'(data_of(d)), 64'(exp));
    endtask

    initial begin
        bus0.host_addr_reg = '0; bus0.reg_rd_start = 1'b0;
        bus1.host_addr_reg = '0; bus1.reg_rd_start = 1'b0;
        repeat (3) tick();
        chk("reset done0", 64'(bus0.reg_rd_done_out), 64'd0);
        chk("reset data0", 64'(bus0.FMAC_REGDOUT), 64'd0);
        chk("reset done1", 64'(bus1.reg_rd_done_out), 64'd0);
        chk("reset data1", 64'(bus1.FMAC_REGDOUT), 64'd0);
        rst = 1'b0;
        tick();
        rd(0, 16'h0022, 32'd0, "reset ch2 tx_bytes");

        // Byte accumulation on ch2: 64 + 1518 + 9000
        strobe(0, 2, 0, 48'd64);
        strobe(0, 2, 0, 48'd1518);
        strobe(0, 2, 0, 48'd9000);
        rd(0, 16'h0022, 32'd10582, "ch2 tx_bytes");
        rd(0, 16'h0020, 32'd3, "ch2 tx_frames");
        rd(0, 16'h0024, 32'd0, "ch2 tx_errors");

        // Error-only RX strobe on ch1
        strobe(1, 1, 1, 48'd1234);
        rd(0, 16'h001A, 32'd1, "ch1 rx_errors");
        rd(0, 16'h0016, 32'd0, "ch1 rx_frames");
        rd(0, 16'h0018, 32'd0, "ch1 rx_bytes");

        // Saturation on ch0 tx_bytes, then coherent hi read from an unrelated address
        strobe(0, 0, 0, 48'hFFFF_FFFF_FF9C);
        strobe(0, 0, 0, 48'd500);
        rd(0, 16'h0002, 32'hFFFF_FFFF, "sat lo");
        rd(0, 16'h0FF1, 32'h0000_FFFF, "sat hi shadow");
        rd(0, 16'h0000, 32'd2, "ch0 tx_frames");

        // Start in T+1 must be ignored
        start_rd(0, 16'h0020);
        tick();
        start_rd(0, 16'h0022);
        tick();
        stop_rd();
        chk("busy done@T+2", 64'(bus0.reg_rd_done_out), 64'd1);
        chk("busy data", 64'(bus0.FMAC_REGDOUT), 64'd3);
        tick();
        chk("busy done@T+3", 64'(bus0.reg_rd_done_out), 64'd0);
        chk("busy data hold", 64'(bus0.FMAC_REGDOUT), 64'd3);
        tick();
        chk("busy done@T+4", 64'(bus0.reg_rd_done_out), 64'd0);

        // Out-of-range reads return 0 and leave hi_shadow alone
        rd(0, 16'h0002, 32'hFFFF_FFFF, "sat lo again");
        rd(0, 16'h0070, 32'd0, "oor ch7");
        rd(0, 16'h002C, 32'd0, "oor idx6");
        rd(0, 16'h0001, 32'h0000_FFFF, "hi after oor");

        // Global clear wins over a coincident strobe
        set_strobe(0, 1, 0, 48'd77);
        clr = 1'b1;
        tick();
        clr_strobe();
        rd(0, 16'h0001, 32'd0, "hi after clr");
        rd(0, 16'h0012, 32'd0, "clr ch1 tx_bytes");
        rd(0, 16'h0010, 32'd0, "clr ch1 tx_frames");
        rd(0, 16'h0002, 32'd0, "clr ch0 tx_bytes");
        rd(0, 16'h0022, 32'd0, "clr ch2 tx_bytes");
        rd(0, 16'h001A, 32'd0, "clr ch1 rx_errors");

        // Clear-on-read race on the second instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) strobe(0, 3, 0, 48'd10);
        start_rd(1, 16'h0030);
        set_strobe(0, 3, 0, 48'd10);
        tick();
        stop_rd();
        clr_strobe();
        chk("cor race done@T+1", 64'(bus1.reg_rd_done_out), 64'd0);
        tick();
        chk("cor race done@T+2", 64'(bus1.reg_rd_done_out), 64'd1);
        chk("cor race data", 64'(bus1.FMAC_REGDOUT), 64'd5);
        rd(1, 16'h0030, 32'd1, "cor after race");
        rd(1, 16'h0030, 32'd0, "cor cleared");
        rd(1, 16'h0032, 32'd60, "cor ch3 tx_bytes");
        rd(0, 16'h0030, 32'd6, "plain ch3 tx_frames");
        rd(0, 16'h0030, 32'd6, "plain ch3 no clear");

        // Reset during an in-flight read
        strobe(0, 0, 0, 48'd7);
        start_rd(0, 16'h0002);
        tick();
        stop_rd();
        rst = 1'b1;
        tick();
        chk("rst-mid done@T+2", 64'(bus0.reg_rd_done_out), 64'd0);
        chk("rst-mid data", 64'(bus0.FMAC_REGDOUT), 64'd0);
        chk("rst-mid data1", 64'(bus1.FMAC_REGDOUT), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst-mid done@T+3", 64'(bus0.reg_rd_done_out), 64'd0);
        rd(0, 16'h0002, 32'd0, "rst-mid counter");
        rd(0, 16'h0031, 32'd0, "rst-mid hi shadow");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
